// File: rtl/alu_pkg.sv
// Shared ALU encodings: op codes, FSM state type and the divide-by-zero fill.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_XOR  = 3'b100,
        OP_SLT  = 3'b101,
        OP_MUL  = 3'b110,
        OP_DIVU = 3'b111
    } alu_op_t;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ITER = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Every bit of a divide-by-zero quotient takes this value.
    localparam logic DIV0_FILL = 1'b1;

endpackage

// File: rtl/alu_iter_unit.sv
// Shared iterative datapath: shift-add multiply (mode 0) or restoring divide (mode 1).
module alu_iter_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             mode,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             hi_nz,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_top;
    logic [WIDTH:0]     div_diff;

    // Both modes start from {0, a}; multiply shifts right, divide shifts left.
    // The partial remainder never exceeds b-1, so the W+1-bit difference MSB is a clean borrow.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
        div_top  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, b_q};
        if (!mode_q)
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};
        else if (!div_diff[WIDTH])
            acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_nxt = {div_top[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= {{WIDTH{1'b0}}, a};
            b_q    <= b;
            mode_q <= mode;
            cnt    <= CW'(WIDTH);
        end else if (step) begin
            acc <= acc_nxt;
            cnt <= cnt - 1'b1;
        end
    end

    // Output is the post-step value so the final step and the result load share one edge.
    assign out   = acc_nxt[WIDTH-1:0];
    assign hi_nz = |acc_nxt[2*WIDTH-1:WIDTH];
    assign last  = (cnt == CW'(1));

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: single-pass logic/arith ops plus iterative MUL/DIVU.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    state_t           state;
    alu_op_t          op_e;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic [WIDTH-1:0] sp_res;
    logic             sp_carry;
    logic             sp_ovf;
    logic             is_iter;
    logic             accept;
    logic             it_mode;
    logic [WIDTH-1:0] it_out;
    logic             it_hi_nz;
    logic             it_last;

    assign op_e   = alu_op_t'(op);
    assign accept = (state == ST_IDLE) && start;
    // DIVU by zero skips iteration and completes like a single-pass op.
    assign is_iter = (op_e == OP_MUL) || ((op_e == OP_DIVU) && (b != '0));

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        dif      = {1'b0, a} - {1'b0, b};
        sp_res   = '0;
        sp_carry = 1'b0;
        sp_ovf   = 1'b0;
        case (op_e)
            OP_AND: sp_res = a & b;
            OP_OR:  sp_res = a | b;
            OP_XOR: sp_res = a ^ b;
            OP_ADD: begin
                sp_res   = sum[WIDTH-1:0];
                sp_carry = sum[WIDTH];
                sp_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sp_res   = dif[WIDTH-1:0];
                sp_carry = dif[WIDTH];
                sp_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: sp_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: begin
                sp_res   = {WIDTH{DIV0_FILL}};
                sp_carry = 1'b1;
            end
        endcase
    end

    alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept && is_iter),
        .mode  (op_e == OP_DIVU),
        .step  (state == ST_ITER),
        .a     (a),
        .b     (b),
        .out   (it_out),
        .hi_nz (it_hi_nz),
        .last  (it_last)
    );

    logic mode_div;
    assign it_mode = mode_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            mode_div <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy     <= 1'b1;
                        mode_div <= (op_e == OP_DIVU);
                        if (is_iter) begin
                            state <= ST_ITER;
                        end else begin
                            state    <= ST_DONE;
                            done     <= 1'b1;
                            result   <= sp_res;
                            zero     <= (sp_res == '0);
                            carry    <= sp_carry;
                            overflow <= sp_ovf;
                        end
                    end
                end
                ST_ITER: begin
                    if (it_last) begin
                        state    <= ST_DONE;
                        done     <= 1'b1;
                        result   <= it_out;
                        zero     <= (it_out == '0);
                        carry    <= it_mode ? 1'b0 : it_hi_nz;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle processor's 16-bit ALU. It adds XOR, signed set-less-than, and iterative unsigned multiply and divide. It produces a full flag set (zero, carry, overflow) valid for every operation, not only subtract. It sits in the execute stage of the multi-cycle datapath, and the control FSM stalls on `busy`.

## Interface
- `WIDTH`, 16: operand and result width; must be ≥ 4.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only when `busy`=0.
- `op` input 3: operation code, captured with `start`.
- `a` input WIDTH: operand 1, captured with `start`.
- `b` input WIDTH: operand 2, captured with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until the cycle `done` is high (inclusive).
- `done` output 1: one-cycle pulse; result and flags are valid from this cycle on.
- `result` output WIDTH: registered result, held until the next `done`.
- `zero` output 1: `result`==0, registered with `result`.
- `carry` output 1: op-specific, see Operation.
- `overflow` output 1: signed overflow for ADD/SUB, else 0.

## Operation
- Op codes:
  - 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR: single-pass.
  - 101 SLT: result = {0…0, signed(a)<signed(b)}, single-pass.
  - 110 MUL: low WIDTH bits of unsigned a×b, iterative.
  - 111 DIVU: unsigned a/b quotient, iterative.
- FSM states IDLE, ITER, DONE.
  - IDLE + `start` → operands and op are latched. Single-pass ops go to DONE. MUL/DIVU go to ITER with counter = WIDTH.
  - ITER: one shift-add (MUL) or one restoring-subtract step (DIVU) per cycle, counter decrements. Counter reaching 1 → DONE.
  - DONE: `result` and flags are loaded, `done`=1, then → IDLE.
- Flags:
  - `carry`:
    - ADD: carry out of bit WIDTH-1.
    - SUB: borrow (a<b unsigned).
    - MUL: 1 if the high WIDTH bits of the 2·WIDTH product are nonzero.
    - DIVU: 1 on divide-by-zero.
    - Logic/SLT: 0.
  - `overflow`:
    - ADD: operands have the same sign and the sum sign differs.
    - SUB: operands have different signs and the difference sign differs from `a`.
- DIVU with b=0: no iteration; goes directly to DONE with result = all ones, carry=1, latency of a single-pass op.
- `start` while `busy`=1 is ignored; the in-flight operation is unaffected.
- `start` in the same cycle as `done`=1 is ignored, because the FSM is not in IDLE. The earliest accept is the cycle after `done`.
- Undefined flag cases do not exist: every op drives every flag.
- Iteration counter width is $clog2(WIDTH+1). The internal product/remainder register is 2·WIDTH bits.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - FSM → IDLE.
  - `busy`=0, `done`=0, `result`=0, `zero`=0, `carry`=0, `overflow`=0.
  - Counter and internal registers are cleared.
- Reset asserted mid-ITER aborts the operation and no `done` is issued. After release, the block accepts `start` on the first clock edge.
- Single-pass latency, with `start` accepted at edge N:
  - `busy` is high during cycle N+1.
  - `done` pulses in cycle N+1.
- Iterative latency, with `start` accepted at edge N:
  - `done` pulses in cycle N+WIDTH+1.
  - `busy` is high in cycles N+1 … N+WIDTH+1.
- Between operations `result` and the flags are stable and change only on the edge that raises `done`.
- Operand inputs may change freely after the accept edge.

## Structure
- Shared package `alu_pkg` holds:
  - the `alu_op_t` 3-bit enum (codes above),
  - the FSM state typedef,
  - a localparam for the divide-by-zero result (all ones).
- The processor control unit imports the same package for op encoding.
- Sub-module `alu_iter_unit` (parameter WIDTH) holds the shared shift-add/restoring-divide datapath and counter. Ports: load, mode, step, a, b, product/quotient out, last.
- Top level `alu_seq` holds the FSM, the single-pass combinational logic, and the output/flag registers.

## Test plan
- WIDTH=16, ADD a=0x7FFF, b=0x0001 → at N+1: result=0x8000, overflow=1, carry=0, zero=0, `done` for exactly one cycle.
- SUB a=5, b=5 → result=0, zero=1, carry=0, overflow=0. SUB a=3, b=5 → result=0xFFFE, carry=1.
- MUL a=300, b=300 → `done` at N+17, result=0x5F90, carry=1. MUL a=0x00FF, b=0x0002 → result=0x01FE, carry=0.
- DIVU a=100, b=7 → result=0x000E at N+17. DIVU a=9, b=0 → result=0xFFFF, carry=1, `done` at N+1.
- Start MUL, pulse `start` with ADD during `busy` → only one `done`, carrying the MUL result. `start` in the `done` cycle → ignored.
- Assert `rst_n`=0 at iteration 8 of DIVU → all outputs 0 immediately. After release, SLT a=0xFFFF, b=0x0001 → result=0x0001 at N+1.
